// File: rtl/lut_logic_cell_pkg.sv
// ============================================================================
// lut_cell_pkg : shared state encoding and configuration bit offsets
// Rev 1.0
// ============================================================================
`default_nettype none

package lut_cell_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_UNCONF  = 2'd0;
    localparam state_t ST_LOADING = 2'd1;
    localparam state_t ST_ACTIVE  = 2'd2;

    function automatic int cfg_w(input int k);
        return (1 << k) + 2;
    endfunction

    function automatic int use_ff_idx(input int k);
        return 1 << k;
    endfunction

    function automatic int ff_init_idx(input int k);
        return (1 << k) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lut_logic_cell_lut.sv
// ============================================================================
// cell_lut : 2**K:1 binary mux tree returning truth[sel]
// Rev 1.0
// ============================================================================
`default_nettype none

module cell_lut #(
    parameter int K = 4
) (
    input  logic [(1 << K)-1:0] truth,
    input  logic [K-1:0]        sel,
    output logic                y
);

    // Level 0 holds the leaves; each level halves the width using sel[l-1].
    for (genvar l = 0; l <= K; l++) begin : g_level
        logic [(1 << (K - l))-1:0] v;
        if (l == 0) begin : g_leaf
            assign v = truth;
        end else begin : g_mux
            for (genvar n = 0; n < (1 << (K - l)); n++) begin : g_node
                assign v[n] = sel[l-1] ? g_level[l-1].v[2*n+1] : g_level[l-1].v[2*n];
            end
        end
    end

    assign y = g_level[K].v[0];

endmodule

`default_nettype wire

// File: rtl/lut_logic_cell.sv
// ============================================================================
// lut_logic_cell : K-input LUT + user FF, configured over a serial chain
// Rev 1.0
// ============================================================================
`default_nettype none

module lut_logic_cell
    import lut_cell_pkg::*;
#(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_en,
    input  logic         cfg_in,
    output logic         cfg_out,
    output logic         cfg_done,
    output logic         cfg_err,
    input  logic         ce,
    input  logic         sr,
    input  logic [K-1:0] in,
    output logic         lut_out,
    output logic         out
);

    localparam int LUT_N       = 1 << K;
    localparam int CFG_W       = cfg_w(K);
    localparam int CNT_W       = $clog2(CFG_W + 1);
    localparam int USE_FF_IDX  = use_ff_idx(K);
    localparam int FF_INIT_IDX = ff_init_idx(K);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

    state_t           state;
    state_t           next_state;
    logic [CFG_W-1:0] cfg_reg;
    logic [CNT_W-1:0] cnt;
    logic             ff;
    logic             err;
    logic             lut;
    logic             active;
    logic             load_commit;
    logic             load_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_UNCONF;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_UNCONF, ST_ACTIVE: begin
                if (cfg_en) next_state = ST_LOADING;
            end
            ST_LOADING: begin
                if (!cfg_en) next_state = (cnt == CNT_FULL) ? ST_ACTIVE : ST_UNCONF;
            end
            default: next_state = ST_UNCONF;
        endcase
    end

    always_comb begin
        active      = (state == ST_ACTIVE);
        load_commit = (state == ST_LOADING) && !cfg_en && (cnt == CNT_FULL);
        load_abort  = (state == ST_LOADING) && !cfg_en && (cnt != CNT_FULL);
    end

    // Shift chain; bits pushed past the top leave through cfg_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_reg <= '0;
            cnt     <= '0;
        end else if (cfg_en) begin
            cfg_reg <= {cfg_reg[CFG_W-2:0], cfg_in};
            if (cnt != CNT_FULL) cnt <= cnt + CNT_W'(1);
        end else if (state == ST_LOADING) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (load_commit) begin
            err <= 1'b0;
        end else if (load_abort) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= 1'b0;
        end else if (load_commit) begin
            ff <= cfg_reg[FF_INIT_IDX];
        end else if (active) begin
            if (sr) begin
                ff <= cfg_reg[FF_INIT_IDX];
            end else if (ce) begin
                ff <= lut;
            end
        end else begin
            ff <= 1'b0;
        end
    end

    cell_lut #(
        .K (K)
    ) u_lut (
        .truth (cfg_reg[LUT_N-1:0]),
        .sel   (in),
        .y     (lut)
    );

    // Gating on registered state keeps partially shifted tables off the outputs.
    assign cfg_out  = cfg_reg[CFG_W-1];
    assign cfg_done = active;
    assign cfg_err  = err;
    assign lut_out  = active & lut;
    assign out      = active & (cfg_reg[USE_FF_IDX] ? ff : lut);

endmodule

`default_nettype wire
